// File: rtl/controller_pkg.sv
// Shared state encoding, default limits and the state-to-output decode for the
// backtracking datapath controller.
package controller_pkg;

    localparam int MAX_CYCLES_DEFAULT = 1023;
    localparam int CNT_W_DEFAULT      = 10;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_INIT   = 4'd1;
    localparam logic [3:0] ST_UPDATE = 4'd2;
    localparam logic [3:0] ST_WAIT   = 4'd3;
    localparam logic [3:0] ST_ALU    = 4'd4;
    localparam logic [3:0] ST_CALC   = 4'd5;
    localparam logic [3:0] ST_CHECK  = 4'd6;
    localparam logic [3:0] ST_POP    = 4'd7;
    localparam logic [3:0] ST_RESUPD = 4'd8;
    localparam logic [3:0] ST_FINISH = 4'd9;
    localparam logic [3:0] ST_ERROR  = 4'd10;

    typedef enum logic [3:0] {
        S_IDLE   = ST_IDLE,
        S_INIT   = ST_INIT,
        S_UPDATE = ST_UPDATE,
        S_WAIT   = ST_WAIT,
        S_ALU    = ST_ALU,
        S_CALC   = ST_CALC,
        S_CHECK  = ST_CHECK,
        S_POP    = ST_POP,
        S_RESUPD = ST_RESUPD,
        S_FINISH = ST_FINISH,
        S_ERROR  = ST_ERROR
    } state_e;

    typedef struct packed {
        logic load_init;
        logic updater;
        logic alu;
        logic cal_res;
        logic poping;
        logic res_updater;
        logic dont_check;
        logic ready;
        logic finish;
    } ctrl_out_t;

    // Strobes are one-hot by construction: each state raises at most one.
    function automatic ctrl_out_t decode_state(input state_e s);
        ctrl_out_t o;
        o = '0;
        o.dont_check = !(s inside {S_IDLE, S_CHECK, S_FINISH, S_ERROR});
        case (s)
            S_IDLE:   o.ready       = 1'b1;
            S_INIT:   o.load_init   = 1'b1;
            S_UPDATE: o.updater     = 1'b1;
            S_ALU:    o.alu         = 1'b1;
            S_CALC:   o.cal_res     = 1'b1;
            S_POP:    o.poping      = 1'b1;
            S_RESUPD: o.res_updater = 1'b1;
            S_FINISH: o.finish      = 1'b1;
            default:  ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/controller_register.sv
// Generic enabled register with synchronous active-high reset to zero.
module Register #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) q_d = d;
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/controller_watchdog.sv
// Saturating run-length counter; flags the cycle on which the count reaches limit.
module watchdog #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             limit_reached
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)                        cnt_d = '0;
        else if (en && cnt_q != limit)  cnt_d = cnt_q + CNT_W'(1);
    end

    // Lookahead so the FSM leaves on the edge where the count hits the limit.
    assign limit_reached = en && !clr && (limit != '0) && (cnt_q == limit - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/controller.sv
// Sequencer for the backtracking datapath: Moore FSM with registered strobes,
// watchdog-bounded runs and a sticky error flag.
//
// state  | meaning
// IDLE   | ready, waiting for start
// INIT   | load entry, init stack
// UPDATE | mark visited, grow stack
// WAIT   | expect datapath update acknowledge
// ALU    | evaluate ALUs, branch on backtrack
// CALC   | compute value[n], shrink stack
// CHECK  | evaluate done / result acknowledge
// POP    | reload indices from stack top
// RESUPD | n <= multi2 index
// FINISH | one-cycle result-valid pulse
// ERROR  | fault recorded, return to IDLE
module controller
    import controller_pkg::*;
#(
    parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic updated,
    input  logic backtrack,
    input  logic done,
    input  logic cal_update,
    output logic load_init,
    output logic updater,
    output logic alu,
    output logic cal_res,
    output logic poping,
    output logic res_updater,
    output logic dont_check,
    output logic ready,
    output logic finish,
    output logic err
);

    state_e    state_q, state_d;
    ctrl_out_t out_q, out_d;
    logic      accept;
    logic      wd_limit;
    logic      err_en;
    logic      err_d;

    assign accept = (state_q == S_IDLE) && start;

    watchdog #(.CNT_W(CNT_W)) u_watchdog (
        .clk           (clk),
        .rst           (rst),
        .en            (state_q != S_IDLE),
        .clr           (accept),
        .limit         (CNT_W'(MAX_CYCLES)),
        .limit_reached (wd_limit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_INIT;
            S_INIT:   state_d = S_UPDATE;
            S_UPDATE: state_d = S_WAIT;
            S_WAIT:   state_d = updated ? S_ALU : S_ERROR;
            S_ALU:    state_d = backtrack ? S_CALC : S_UPDATE;
            S_CALC:   state_d = S_CHECK;
            S_CHECK: begin
                if (!cal_update) state_d = S_ERROR;
                else if (done)   state_d = S_FINISH;
                else             state_d = S_POP;
            end
            S_POP:    state_d = S_RESUPD;
            S_RESUPD: state_d = S_UPDATE;
            S_FINISH: state_d = S_IDLE;
            S_ERROR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (wd_limit && state_q != S_ERROR) state_d = S_ERROR;
    end

    assign out_d = decode_state(state_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= decode_state(S_IDLE);
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Set on entry to ERROR, cleared only when a new run is accepted.
    assign err_d  = (state_d == S_ERROR);
    assign err_en = accept || err_d;

    Register #(.W(1)) u_err_reg (
        .clk (clk),
        .rst (rst),
        .en  (err_en),
        .d   (err_d),
        .q   (err)
    );

    assign load_init   = out_q.load_init;
    assign updater     = out_q.updater;
    assign alu         = out_q.alu;
    assign cal_res     = out_q.cal_res;
    assign poping      = out_q.poping;
    assign res_updater = out_q.res_updater;
    assign dont_check  = out_q.dont_check;
    assign ready       = out_q.ready;
    assign finish      = out_q.finish;

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller; datapath acknowledges are driven step by step.
module tb_controller;
    import controller_pkg::*;

    localparam int WD_MAX = 16;

    logic clk = 1'b0;
    logic rst, start, updated, backtrack, done, cal_update;
    logic load_init, updater, alu, cal_res, poping, res_updater;
    logic dont_check, ready, finish, err;
    logic [5:0] strobes;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign strobes = {load_init, updater, alu, cal_res, poping, res_updater};

    controller #(.MAX_CYCLES(WD_MAX), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .updated     (updated),
        .backtrack   (backtrack),
        .done        (done),
        .cal_update  (cal_update),
        .load_init   (load_init),
        .updater     (updater),
        .alu         (alu),
        .cal_res     (cal_res),
        .poping      (poping),
        .res_updater (res_updater),
        .dont_check  (dont_check),
        .ready       (ready),
        .finish      (finish),
        .err         (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected vector: {strobes[5:0], dont_check, ready, finish, err}
    task automatic expect_out(input string tag, input logic [5:0] s, input logic dc,
                              input logic rdy, input logic fin, input logic e);
        logic [9:0] obs, exp_v;
        obs   = {strobes, dont_check, ready, finish, err};
        exp_v = {s, dc, rdy, fin, e};
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] LD   = 6'b100000;
    localparam logic [5:0] UPD  = 6'b010000;
    localparam logic [5:0] ALU  = 6'b001000;
    localparam logic [5:0] CAL  = 6'b000100;
    localparam logic [5:0] POP  = 6'b000010;
    localparam logic [5:0] RES  = 6'b000001;

    initial begin
        rst = 1'b1; start = 1'b0; updated = 1'b0; backtrack = 1'b0;
        done = 1'b0; cal_update = 1'b0;
        tick(); tick();
        rst = 1'b0;
        expect_out("reset_idle", NONE, 1'b0, 1'b1, 1'b0, 1'b0);

        // Run 1: one backtrack=0 loop, a start during the run, then done.
        updated = 1'b1; cal_update = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        expect_out("r1_init", LD, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect_out("r1_update", UPD, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect_out("r1_wait", NONE, 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick(); start = 1'b0;
        expect_out("r1_alu_start_ignored", ALU, 1'b1, 1'b0, 1'b0, 1'b0);
        backtrack = 1'b0;
        tick(); expect_out("r1_bt0_update", UPD, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect_out("r1_wait2", NONE, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect_out("r1_alu2", ALU, 1'b1, 1'b0, 1'b0, 1'b0);
        backtrack = 1'b1;
        tick(); expect_out("r1_bt1_calc", CAL, 1'b1, 1'b0, 1'b0, 1'b0);
        backtrack = 1'b0; done = 1'b1;
        tick(); expect_out("r1_check", NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); expect_out("r1_finish", NONE, 1'b0, 1'b0, 1'b1, 1'b0);
        done = 1'b0;
        tick(); expect_out("r1_idle", NONE, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("r1_idle_no_queue", NONE, 1'b0, 1'b1, 1'b0, 1'b0);

        // Run 2: done=0 path through POP/RESUPD, then reset mid-run.
        start = 1'b1;
        tick(); start = 1'b0;
        expect_out("r2_init", LD, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        backtrack = 1'b1;
        tick(); expect_out("r2_alu", ALU, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); backtrack = 1'b0;
        tick(); expect_out("r2_check_notdone", NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); expect_out("r2_pop", POP, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect_out("r2_resupd", RES, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect_out("r2_update", UPD, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(); rst = 1'b0;
        expect_out("r2_midrun_reset", NONE, 1'b0, 1'b1, 1'b0, 1'b0);

        // Run 3: missing update acknowledge in WAIT.
        updated = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        expect_out("r3_wait", NONE, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect_out("r3_error", NONE, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); expect_out("r3_idle_err", NONE, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(); expect_out("r3_err_held", NONE, 1'b0, 1'b1, 1'b0, 1'b1);

        // Run 4: endless backtrack=0 loop trips the watchdog after WD_MAX cycles.
        updated = 1'b1; backtrack = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        expect_out("r4_init_err_clr", LD, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= WD_MAX; i++) tick();
        expect_out("r4_cycle16_alu", ALU, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect_out("r4_wd_error", NONE, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); expect_out("r4_wd_idle", NONE, 1'b0, 1'b1, 1'b0, 1'b1);

        // Run 5: missing result acknowledge in CHECK.
        cal_update = 1'b0; backtrack = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        expect_out("r5_calc", CAL, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect_out("r5_check", NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); expect_out("r5_error", NONE, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); expect_out("r5_idle", NONE, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameter MAX_CYCLES, default 1023: watchdog limit on cycles per run.
REQ-002 Parameter CNT_W, default 10: watchdog counter width; SHALL satisfy 2^CNT_W > MAX_CYCLES.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 updated  input  1  datapath update acknowledge (sticky once set).
REQ-007 backtrack  input  1  datapath combinational backtrack flag, valid while alu=1.
REQ-008 done  input  1  datapath completion flag, valid while dont_check=0.
REQ-009 cal_update  input  1  datapath result-computed acknowledge (sticky).
REQ-010 load_init  output  1  datapath strobe: load entry, init stack.
REQ-011 updater  output  1  datapath strobe: mark visited, grow stack.
REQ-012 alu  output  1  datapath strobe: push operands, evaluate ALUs.
REQ-013 cal_res  output  1  datapath strobe: compute value[n], shrink stack.
REQ-014 poping  output  1  datapath strobe: reload indices from stack top.
REQ-015 res_updater  output  1  datapath strobe: n <= multi2 index.
REQ-016 dont_check  output  1  suppresses datapath done evaluation.
REQ-017 ready  output  1  controller idle, start accepted.
REQ-018 finish  output  1  one-cycle pulse: result valid.
REQ-019 err  output  1  sticky fault flag (watchdog or missing acknowledge).

Function
REQ-020 FSM states SHALL be IDLE, INIT, UPDATE, WAIT, ALU, CALC, CHECK, POP, RESUPD, FINISH, ERROR; all outputs registered-state decoded (Moore), except transitions reading backtrack in ALU.
REQ-021 IDLE: ready=1; start=1 -> INIT, clears err and watchdog counter; else stay.
REQ-022 INIT: load_init=1, dont_check=1, one cycle -> UPDATE.
REQ-023 UPDATE: updater=1, dont_check=1, one cycle -> WAIT.
REQ-024 WAIT: dont_check=1; updated=1 -> ALU; updated=0 -> ERROR.
REQ-025 ALU: alu=1, dont_check=1; backtrack=1 -> CALC; backtrack=0 -> UPDATE.
REQ-026 CALC: cal_res=1, dont_check=1, one cycle -> CHECK.
REQ-027 CHECK: dont_check=0; cal_update=0 -> ERROR; else done=1 -> FINISH; else -> POP.
REQ-028 POP: poping=1, dont_check=1 -> RESUPD; RESUPD: res_updater=1, dont_check=1 -> UPDATE.
REQ-029 FINISH: finish=1 exactly one cycle -> IDLE.
REQ-030 ERROR: err set, all strobes 0, one cycle -> IDLE; err held until next accepted start.
REQ-031 dont_check SHALL be 1 in every state except CHECK, IDLE, FINISH, ERROR.
REQ-032 At most one of load_init/updater/alu/cal_res/poping/res_updater SHALL be 1 in any cycle.
REQ-033 Watchdog counts every cycle outside IDLE; on reaching MAX_CYCLES -> ERROR regardless of state, priority over all other transitions; counter saturates, never wraps.
REQ-034 start asserted outside IDLE SHALL be ignored, not queued.

Reset
REQ-035 rst=1 at an edge -> IDLE; ready=1; all strobes, finish, err, counter = 0; applies mid-run with priority over every transition.

Structure
REQ-036 State encoding localparams and MAX_CYCLES default SHALL live in a shared package used by controller and bench.
REQ-037 Watchdog SHALL be a sub-module named watchdog (en, clr, limit-reached output); err flag SHALL use the existing Register module.

Verification (bench uses behavioural datapath stub)
REQ-038 rst=1 two cycles -> ready=1, all strobes 0, err=0, finish=0.
REQ-039 start pulse in IDLE at cycle t -> load_init=1 at t+1 only, updater=1 at t+2, alu=1 at t+4 with updated=1.
REQ-040 backtrack=0 in ALU -> updater=1 next cycle; backtrack=1 -> cal_res=1 next cycle, dont_check=0 the cycle after.
REQ-041 done=1, cal_update=1 in CHECK -> finish=1 for one cycle, ready=1 next cycle; done=0 -> poping then res_updater then updater.
REQ-042 MAX_CYCLES=16, stub never asserts done -> err=1 after 16 run cycles, strobes 0, ready=1; updated held 0 -> err from WAIT.
REQ-043 start during run ignored (no load_init); rst mid-run -> IDLE at next edge, no finish pulse.
